and_nand_sweep_ctrl: RTL and testbench
======================================

Name: and_nand_sweep_ctrl

Overview:
Self-test sequencer for the two-input AND/NAND gate datapath. On a start pulse it drives both gate inputs through the full truth table (00, 01, 10, 11), waits a settle time per vector, then checks both gate outputs against expected values. It logs the error count and the first failing vector, and reports done/pass. It sits between a test/control register block and one and_nand instance.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range >= 1
PASSES, 1, number of full truth-table sweeps per start; legal range >= 1
ERR_W, 8, width of the error counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin a sweep; honoured only in IDLE
abort  input  1  terminate the sweep; honoured in any non-IDLE state
and_out  input  1  AND output from the gate under control
nand_out  input  1  NAND output from the gate under control
in0  output  1  gate input 0, registered
in1  output  1  gate input 1, registered
busy  output  1  high in SETTLE and CHECK
done  output  1  one-cycle pulse at sweep completion
pass  output  1  high after a completed sweep with zero errors; held until the next accepted start
err_count  output  ERR_W  mismatch count, saturating
fail_valid  output  1  at least one mismatch logged this run
fail_vec  output  2  {in1,in0} of the first mismatch; valid when fail_valid is high

Behaviour:
- Reset: rst_n low at a rising edge sets state IDLE and clears all outputs to 0. This applies mid-sweep too; no done pulse is produced.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE + start (abort low):
  - clear err_count, fail_valid, fail_vec and pass;
  - set vector index = 0 and drive {in1,in0} = 00;
  - load the settle counter with SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: decrement the counter; at 0 go to CHECK.
- Vector hold time: each vector is held for exactly SETTLE_CYCLES cycles in SETTLE plus 1 cycle in CHECK.
- CHECK compares in the same cycle:
  - expected and = in0&in1; expected nand = ~(in0&in1);
  - a mismatch on either output counts as one error for that vector;
  - err_count increments and saturates at 2^ERR_W-1;
  - on the first mismatch, set fail_valid and capture fail_vec; later mismatches do not overwrite it.
- CHECK exit, index < 3: increment the index, drive the next vector, reload the counter, go to SETTLE.
- CHECK exit, index = 3: if passes remain, wrap the index to 0 (vector 00) and go to SETTLE; otherwise go to DONE.
- DONE, lasts one cycle:
  - done=1, busy=0;
  - pass = (err_count==0 && !fail_valid), including any increment made in the final CHECK;
  - in0/in1 return to 0; next state IDLE.
- Latency: start sampled at edge 0 → busy high in cycles 1 … N, where N = PASSES*4*(SETTLE_CYCLES+1); done high in cycle N+1.
- abort (non-IDLE): next state IDLE, in0=in1=0, busy=0, no done, pass=0. err_count and fail info are retained for debug.
- start and abort together in IDLE: abort wins and start is ignored.
- start while busy or in DONE is ignored.
- Sampled gate outputs are treated as combinational from in0/in1, with no synchronisers.

Decomposition:
- Package and_nand_pkg:
  - state enum (IDLE/SETTLE/CHECK/DONE);
  - VEC_LAST = 2'd3;
  - function exp_out(vec) returning {and,nand}.
- Sub-module and_nand_checker, combinational compare plus sticky log:
  - inputs: check strobe, clear, vec, and_out, nand_out;
  - outputs: err_count (saturating), fail_valid, fail_vec.
- The top level keeps the FSM, vector index, pass counter and settle counter.

Test Plan:
1. Correct gate, SETTLE=2, PASSES=1, start at cycle 0 → {in1,in0} = 00,01,10,11, each held 3 cycles (cycles 1–12); busy cycles 1–12; done in cycle 13; pass=1, err_count=0, fail_valid=0.
2. nand_out stuck at 0, defaults → err_count=3, fail_valid=1, fail_vec=00, pass=0, done in cycle 13.
3. PASSES=3, and_out stuck at 1 → err_count=9, fail_vec=00, done in cycle 37, pass=0.
4. ERR_W=2, PASSES=2, both outputs inverted → err_count saturates at 3 (8 mismatches), fail_vec=00, pass=0.
5. Abort at cycle 5 (during vector 01) → cycle 6: IDLE, in0=in1=0, busy=0; no done pulse; a new start then completes a normal sweep. start+abort together in IDLE → stays IDLE, busy never rises.
6. rst_n low at cycle 7 mid-sweep → next cycle all outputs 0, state IDLE. start during busy (cycle 4) → ignored, completion still in cycle 13.

Source files
------------

// File: rtl/and_nand_pkg.sv
// Shared types and helpers for the AND/NAND self-test sequencer.
// Holds the FSM state type, the last vector index and the expected gate response.
package and_nand_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [1:0] VEC_LAST = 2'd3;

    // Expected {and, nand} for vector {in1, in0}
    function automatic logic [1:0] exp_out(input logic [1:0] vec);
        logic a;
        a = vec[1] & vec[0];
        return {a, ~a};
    endfunction

endpackage

// File: rtl/and_nand_checker.sv
// Compares sampled gate outputs against the truth table.
// Keeps a saturating error count and a sticky record of the first failing vector.
module and_nand_checker
    import and_nand_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             check,
    input  logic             clear,
    input  logic [1:0]       vec,
    input  logic             and_out,
    input  logic             nand_out,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [1:0]       fail_vec
);

    logic mismatch;

    assign mismatch = ({and_out, nand_out} != exp_out(vec));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= 2'b00;
        end else if (check && mismatch) begin
            if (err_count != '1) begin
                err_count <= err_count + ERR_W'(1);
            end
            if (!fail_valid) begin
                fail_valid <= 1'b1;
                fail_vec   <= vec;
            end
        end
    end

endmodule

// File: rtl/and_nand_sweep_ctrl.sv
// Self-test sequencer: sweeps the AND/NAND gate through its truth table.
// Reports done/pass plus error count and the first failing vector.
module and_nand_sweep_ctrl
    import and_nand_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             and_out,
    input  logic             nand_out,
    output logic             in0,
    output logic             in1,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [1:0]       fail_vec
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CW-1:0] LOAD  = CW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PLAST = PW'(PASSES - 1);

    state_t        state, state_d;
    logic [1:0]    vec, vec_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [PW-1:0] pidx, pidx_d;
    logic          pass_q, pass_d;
    logic          clear;
    logic          pass_now;

    and_nand_checker #(
        .ERR_W(ERR_W)
    ) u_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .check     (state == CHECK),
        .clear     (clear),
        .vec       (vec),
        .and_out   (and_out),
        .nand_out  (nand_out),
        .err_count (err_count),
        .fail_valid(fail_valid),
        .fail_vec  (fail_vec)
    );

    // Checker registers already include the final CHECK result here
    assign pass_now = (err_count == '0) && !fail_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            vec    <= 2'b00;
            cnt    <= '0;
            pidx   <= '0;
            pass_q <= 1'b0;
        end else begin
            state  <= state_d;
            vec    <= vec_d;
            cnt    <= cnt_d;
            pidx   <= pidx_d;
            pass_q <= pass_d;
        end
    end

    always_comb begin
        state_d = state;
        vec_d   = vec;
        cnt_d   = cnt;
        pidx_d  = pidx;
        pass_d  = pass_q;
        clear   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    clear   = 1'b1;
                    pass_d  = 1'b0;
                    vec_d   = 2'b00;
                    cnt_d   = LOAD;
                    pidx_d  = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            CHECK: begin
                cnt_d = LOAD;
                if (vec != VEC_LAST) begin
                    vec_d   = vec + 2'd1;
                    state_d = SETTLE;
                end else if (pidx != PLAST) begin
                    pidx_d  = pidx + PW'(1);
                    vec_d   = 2'b00;
                    state_d = SETTLE;
                end else begin
                    vec_d   = 2'b00;
                    state_d = DONE;
                end
            end
            DONE: begin
                pass_d  = pass_now;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_d = IDLE;
            vec_d   = 2'b00;
            pass_d  = 1'b0;
        end
    end

    assign in0  = vec[0];
    assign in1  = vec[1];
    assign busy = (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = pass_q | (done & pass_now);

endmodule

// File: tb/tb_and_nand_sweep_ctrl.sv
// Scoreboard bench for and_nand_sweep_ctrl with three parameterisations.
// Faulty gate models feed the DUTs; sweep results are checked on done.
module tb_and_nand_sweep_ctrl;

    typedef struct {
        logic [7:0] err;
        logic       fv;
        logic [1:0] vec;
        logic       ps;
        int         at;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic start_c = 1'b0;
    int   fa = 0;
    int   cyc = 0;
    int   nvec = 0;
    int   nmis = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    logic       in0_a, in1_a, and_a, nand_a, busy_a, done_a, pass_a;
    logic       fv_a;
    logic [1:0] fvec_a;
    logic [7:0] err_a;
    logic       in0_b, in1_b, and_b, nand_b, busy_b, done_b, pass_b;
    logic       fv_b;
    logic [1:0] fvec_b;
    logic [7:0] err_b;
    logic       in0_c, in1_c, and_c, nand_c, busy_c, done_c, pass_c;
    logic       fv_c;
    logic [1:0] fvec_c;
    logic [1:0] err_c;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate models: 0 good, 1 nand stuck 0, 2 and stuck 1, 3 both inverted
    function automatic logic g_and(input int f, input logic x, input logic y);
        if (f == 2) return 1'b1;
        if (f == 3) return ~(x & y);
        return x & y;
    endfunction

    function automatic logic g_nand(input int f, input logic x, input logic y);
        if (f == 1) return 1'b0;
        if (f == 3) return x & y;
        return ~(x & y);
    endfunction

    assign and_a  = g_and(fa, in1_a, in0_a);
    assign nand_a = g_nand(fa, in1_a, in0_a);
    assign and_b  = g_and(2, in1_b, in0_b);
    assign nand_b = g_nand(2, in1_b, in0_b);
    assign and_c  = g_and(3, in1_c, in0_c);
    assign nand_c = g_nand(3, in1_c, in0_c);

    and_nand_sweep_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
        .and_out(and_a), .nand_out(nand_a), .in0(in0_a), .in1(in1_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .fail_valid(fv_a), .fail_vec(fvec_a)
    );

    and_nand_sweep_ctrl #(.PASSES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
        .and_out(and_b), .nand_out(nand_b), .in0(in0_b), .in1(in1_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .fail_valid(fv_b), .fail_vec(fvec_b)
    );

    and_nand_sweep_ctrl #(.ERR_W(2), .PASSES(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort),
        .and_out(and_c), .nand_out(nand_c), .in0(in0_c), .in1(in1_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
        .fail_valid(fv_c), .fail_vec(fvec_c)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [7:0] err,
                       input logic fv, input logic [1:0] fvec, input logic ps);
        chk({tag, "_err_count"}, 32'(err), 32'(e.err));
        chk({tag, "_fail_valid"}, 32'(fv), 32'(e.fv));
        if (e.fv) chk({tag, "_fail_vec"}, 32'(fvec), 32'(e.vec));
        chk({tag, "_pass"}, 32'(ps), 32'(e.ps));
        chk({tag, "_done_cycle"}, cyc, e.at);
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (done_a) begin
            if (qa.size() == 0) chk("a_spurious_done", 1, 0);
            else begin
                e = qa.pop_front();
                cmp("a", e, err_a, fv_a, fvec_a, pass_a);
            end
        end
        if (done_b) begin
            if (qb.size() == 0) chk("b_spurious_done", 1, 0);
            else begin
                e = qb.pop_front();
                cmp("b", e, err_b, fv_b, fvec_b, pass_b);
            end
        end
        if (done_c) begin
            if (qc.size() == 0) chk("c_spurious_done", 1, 0);
            else begin
                e = qc.pop_front();
                cmp("c", e, {6'd0, err_c}, fv_c, fvec_c, pass_c);
            end
        end
    end

    // Pulse start on one DUT; returns #1 after the sampling edge (cycle 1)
    task automatic start_sweep(input int which, input logic push,
                               input logic [7:0] err, input logic fv,
                               input logic [1:0] vec, input logic ps,
                               input int n);
        exp_t e;
        @(negedge clk);
        case (which)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        e.err = err;
        e.fv  = fv;
        e.vec = vec;
        e.ps  = ps;
        e.at  = cyc + n;
        if (push) begin
            case (which)
                0: qa.push_back(e);
                1: qb.push_back(e);
                default: qc.push_back(e);
            endcase
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_a",
            {in1_a, in0_a, busy_a, done_a, pass_a, fv_a, fvec_a, err_a}, 0);
        chk("reset_busy_b", {busy_b, done_b, pass_b}, 0);
        chk("reset_busy_c", {busy_c, done_c, pass_c}, 0);
        rst_n = 1'b1;

        // Good gate: vector sequence and busy window
        fa = 0;
        start_sweep(0, 1'b1, 8'd0, 1'b0, 2'b00, 1'b1, 12);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("t1_busy_c%0d", k), 32'(busy_a), 1);
            chk($sformatf("t1_vec_c%0d", k), 32'({in1_a, in0_a}),
                32'((k - 1) / 3));
        end
        @(negedge clk);
        chk("t1_busy_c13", 32'(busy_a), 0);
        chk("t1_in_c13", 32'({in1_a, in0_a}), 0);
        @(negedge clk);
        chk("t1_pass_held", 32'(pass_a), 1);
        chk("t1_done_low", 32'(done_a), 0);

        // nand stuck at 0, with an ignored start at cycle 4
        fa = 1;
        start_sweep(0, 1'b1, 8'd3, 1'b1, 2'b00, 1'b0, 12);
        repeat (3) @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (12) @(negedge clk);
        chk("t2_pass_after", 32'(pass_a), 0);

        // Abort during vector 01
        fa = 0;
        start_sweep(0, 1'b0, 8'd0, 1'b0, 2'b00, 1'b0, 0);
        repeat (5) @(negedge clk);
        chk("t5_vec_c5", 32'({in1_a, in0_a}), 1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("t5_abort_state", {in1_a, in0_a, busy_a, done_a, pass_a}, 0);
        repeat (20) @(negedge clk);
        start_sweep(0, 1'b1, 8'd0, 1'b0, 2'b00, 1'b1, 12);
        repeat (14) @(negedge clk);

        // start and abort together in IDLE
        @(negedge clk);
        start_a = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("t5_idle_busy_%0d", k), 32'(busy_a), 0);
        end

        // Multi-pass and saturation instances
        start_sweep(1, 1'b1, 8'd9, 1'b1, 2'b00, 1'b0, 36);
        start_sweep(2, 1'b1, 8'd3, 1'b1, 2'b00, 1'b0, 24);
        repeat (40) @(negedge clk);

        // Reset mid-sweep after two logged errors
        fa = 1;
        start_sweep(0, 1'b0, 8'd0, 1'b0, 2'b00, 1'b0, 0);
        repeat (7) @(negedge clk);
        chk("t6_err_before_reset", 32'(err_a), 2);
        chk("t6_fv_before_reset", 32'({fv_a, fvec_a}), 32'h4);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_reset_outputs",
            {in1_a, in0_a, busy_a, done_a, pass_a, fv_a, fvec_a, err_a}, 0);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("t6_idle_after_reset", 32'(busy_a), 0);

        chk("pending_a", qa.size(), 0);
        chk("pending_b", qb.size(), 0);
        chk("pending_c", qc.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
